// File: rtl/conv_loop_sequencer_pkg.sv
// Shared definitions for the convolution loop sequencer: field widths,
// default layer geometry and controller state encodings.
package conv_loop_sequencer_pkg;

    localparam int ITER_W = 4;
    localparam int CHAN_W = 2;

    localparam int DEF_OUT_SIZE     = 2;
    localparam int DEF_K            = 3;
    localparam int DEF_IN_CHANNEL   = 1;
    localparam int DEF_OUT_CHANNEL  = 1;
    localparam int DEF_DRAIN_CYCLES = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/conv_loop_sequencer_loop_counter.sv
// Wrapping 0..MAX counter; wrap is the carry into the next-outer loop level.
// en lets the parent freeze the whole chain without breaking the carry path.
module conv_loop_sequencer_loop_counter
    import conv_loop_sequencer_pkg::*;
#(
    parameter int W   = ITER_W,
    parameter int MAX = 1
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] next_count,
    output logic         wrap
);

    logic at_max;

    assign at_max = (count == W'(MAX));
    assign wrap   = inc && at_max;

    // NOTE: default assignment first so no path through always_comb leaves next_count unassigned (no latch).
    always_comb begin
        next_count = count;
        if (clr)
            next_count = '0;
        else if (inc && en)
            next_count = at_max ? '0 : count + W'(1);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= next_count;
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Nested-loop iterator generator for one convolution layer pass, with MAC
// framing strobes and a drain phase covering the downstream address pipeline.
module conv_loop_sequencer
    import conv_loop_sequencer_pkg::*;
#(
    parameter int OUT_SIZE     = DEF_OUT_SIZE,
    parameter int K            = DEF_K,
    parameter int IN_CHANNEL   = DEF_IN_CHANNEL,
    parameter int OUT_CHANNEL  = DEF_OUT_CHANNEL,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic [ITER_W-1:0] r,
    output logic [ITER_W-1:0] c,
    output logic [ITER_W-1:0] i,
    output logic [ITER_W-1:0] j,
    output logic [CHAN_W-1:0] in_chan_idx,
    output logic [CHAN_W-1:0] out_chan_idx,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    if (OUT_SIZE < 1 || OUT_SIZE > 16 || K < 1 || K > 16 ||
        IN_CHANNEL < 1 || IN_CHANNEL > 4 || OUT_CHANNEL < 1 || OUT_CHANNEL > 4 ||
        DRAIN_CYCLES < 1) begin : g_bad_params
        $error("conv_loop_sequencer: geometry exceeds iterator/channel widths");
    end

    logic [1:0]         state, state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               start_pass, step, not_final;
    logic               j_wrap, i_wrap, ic_wrap, c_wrap, r_wrap, oc_wrap;
    logic [ITER_W-1:0]  r_nx, c_nx, i_nx, j_nx;
    logic [CHAN_W-1:0]  ic_nx, oc_nx;
    logic               valid_d, first_d, last_d;

    assign start_pass = (state == ST_IDLE) && start;
    assign step       = (state == ST_RUN) && !stall;
    // oc_wrap marks the step off the final tuple; freezing the chain keeps the last tuple visible in DRAIN.
    assign not_final  = !oc_wrap;

    conv_loop_sequencer_loop_counter #(.W(ITER_W), .MAX(K - 1)) u_j (
        .clock(clock), .rst_n(rst_n), .clr(start_pass), .inc(step), .en(not_final),
        .count(j), .next_count(j_nx), .wrap(j_wrap));
    conv_loop_sequencer_loop_counter #(.W(ITER_W), .MAX(K - 1)) u_i (
        .clock(clock), .rst_n(rst_n), .clr(start_pass), .inc(j_wrap), .en(not_final),
        .count(i), .next_count(i_nx), .wrap(i_wrap));
    conv_loop_sequencer_loop_counter #(.W(CHAN_W), .MAX(IN_CHANNEL - 1)) u_ic (
        .clock(clock), .rst_n(rst_n), .clr(start_pass), .inc(i_wrap), .en(not_final),
        .count(in_chan_idx), .next_count(ic_nx), .wrap(ic_wrap));
    conv_loop_sequencer_loop_counter #(.W(ITER_W), .MAX(OUT_SIZE - 1)) u_c (
        .clock(clock), .rst_n(rst_n), .clr(start_pass), .inc(ic_wrap), .en(not_final),
        .count(c), .next_count(c_nx), .wrap(c_wrap));
    conv_loop_sequencer_loop_counter #(.W(ITER_W), .MAX(OUT_SIZE - 1)) u_r (
        .clock(clock), .rst_n(rst_n), .clr(start_pass), .inc(c_wrap), .en(not_final),
        .count(r), .next_count(r_nx), .wrap(r_wrap));
    conv_loop_sequencer_loop_counter #(.W(CHAN_W), .MAX(OUT_CHANNEL - 1)) u_oc (
        .clock(clock), .rst_n(rst_n), .clr(start_pass), .inc(r_wrap), .en(not_final),
        .count(out_chan_idx), .next_count(oc_nx), .wrap(oc_wrap));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)             state_next = ST_RUN;
            ST_RUN:   if (oc_wrap)           state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == '0)   state_next = ST_DONE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from next-cycle counter values so they register alongside the tuple.
    assign valid_d = (state_next == ST_RUN);
    assign first_d = valid_d && (j_nx == '0) && (i_nx == '0) && (ic_nx == '0);
    assign last_d  = valid_d && (j_nx == ITER_W'(K - 1)) && (i_nx == ITER_W'(K - 1)) &&
                     (ic_nx == CHAN_W'(IN_CHANNEL - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            mac_valid <= valid_d;
            mac_first <= first_d;
            mac_last  <= last_d;
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DONE);
            if (oc_wrap)
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
            else if (state == ST_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed bench: default geometry (full passes, stall, start held, mid-pass reset)
// and a 1x1-kernel, two-channel instance driven from a per-cycle vector table.
module tb_conv_loop_sequencer;

    localparam int N_TUPLES = 36;
    localparam int DRAIN    = 10;

    typedef struct packed {
        logic [3:0] r, c, i, j;
        logic [1:0] ic, oc;
        logic       first, last;
    } tup_t;

    typedef struct packed {
        logic       start, stall;
        logic [1:0] ic, oc;
        logic       valid, first, last, busy, done;
    } vec_t;

    logic       clock, rst_n, start, stall;
    logic [3:0] r, c, i, j;
    logic [1:0] in_chan_idx, out_chan_idx;
    logic       mac_valid, mac_first, mac_last, busy, done;

    logic       start_s, stall_s;
    logic [3:0] r_s, c_s, i_s, j_s;
    logic [1:0] ic_s, oc_s;
    logic       valid_s, first_s, last_s, busy_s, done_s;

    int   n_cmp = 0;
    int   n_err = 0;
    tup_t tup [N_TUPLES];
    vec_t vec [19];

    conv_loop_sequencer dut (
        .clock(clock), .rst_n(rst_n), .start(start), .stall(stall),
        .r(r), .c(c), .i(i), .j(j), .in_chan_idx(in_chan_idx), .out_chan_idx(out_chan_idx),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .busy(busy), .done(done));

    conv_loop_sequencer #(.OUT_SIZE(1), .K(1), .IN_CHANNEL(2), .OUT_CHANNEL(2), .DRAIN_CYCLES(10)) dut_s (
        .clock(clock), .rst_n(rst_n), .start(start_s), .stall(stall_s),
        .r(r_s), .c(c_s), .i(i_s), .j(j_s), .in_chan_idx(ic_s), .out_chan_idx(oc_s),
        .mac_valid(valid_s), .mac_first(first_s), .mac_last(last_s),
        .busy(busy_s), .done(done_s));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] tuple_obs();
        return {r, c, i, j, in_chan_idx, out_chan_idx, mac_first, mac_last};
    endfunction

    function automatic vec_t v(input logic st, input logic sl, input logic [1:0] ic, input logic [1:0] oc,
                               input logic vl, input logic fi, input logic la, input logic bs, input logic dn);
        return '{start: st, stall: sl, ic: ic, oc: oc, valid: vl, first: fi, last: la, busy: bs, done: dn};
    endfunction

    // One pass from IDLE; optional stall window starting at the cycle tuple stall_at is shown.
    task automatic run_pass(input int stall_at, input int stall_len, input bit hold_start);
        int n_valid;
        int idx;
        n_valid = N_TUPLES + stall_len;
        start = 1'b1;
        @(negedge clock);
        if (!hold_start) start = 1'b0;
        for (int t = 0; t <= n_valid + DRAIN; t++) begin
            if (t < n_valid) begin
                if (stall_at < 0 || t <= stall_at) idx = t;
                else if (t <= stall_at + stall_len) idx = stall_at;
                else idx = t - stall_len;
                check($sformatf("tuple t=%0d", t), {tuple_obs(), mac_valid, busy, done}, {tup[idx], 3'b110});
            end else if (t < n_valid + DRAIN) begin
                check($sformatf("drain t=%0d", t), {r, c, i, j, mac_valid, mac_first, mac_last, busy, done},
                      {4'd1, 4'd1, 4'd2, 4'd2, 5'b00010});
            end else begin
                check("done_pulse", {mac_valid, busy, done}, 3'b011);
            end
            stall = (stall_at >= 0 && t >= stall_at && t < stall_at + stall_len);
            @(negedge clock);
        end
        check("idle_after_done", {mac_valid, busy, done}, 3'b000);
    endtask

    initial begin
        int n;
        n = 0;
        for (int ko = 0; ko < 1; ko++)
            for (int kr = 0; kr < 2; kr++)
                for (int kc = 0; kc < 2; kc++)
                    for (int kic = 0; kic < 1; kic++)
                        for (int ki = 0; ki < 3; ki++)
                            for (int kj = 0; kj < 3; kj++) begin
                                tup[n] = '{r: 4'(kr), c: 4'(kc), i: 4'(ki), j: 4'(kj), ic: 2'(kic), oc: 2'(ko),
                                           first: (ki == 0 && kj == 0 && kic == 0),
                                           last: (ki == 2 && kj == 2 && kic == 0)};
                                n++;
                            end

        vec[0] = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec[1] = v(0, 0, 0, 0, 1, 1, 0, 1, 0);
        vec[2] = v(0, 1, 1, 0, 1, 0, 1, 1, 0);
        vec[3] = v(0, 0, 1, 0, 1, 0, 1, 1, 0);
        vec[4] = v(0, 0, 0, 1, 1, 1, 0, 1, 0);
        vec[5] = v(0, 0, 1, 1, 1, 0, 1, 1, 0);
        for (int k = 6; k < 16; k++) vec[k] = v(0, (k == 8), 1, 1, 0, 0, 0, 1, 0);
        vec[16] = v(1, 0, 1, 1, 0, 0, 0, 1, 1);
        vec[17] = v(0, 0, 1, 1, 0, 0, 0, 0, 0);
        vec[18] = v(0, 0, 0, 0, 1, 1, 0, 1, 0);
        vec[17].start = 1'b1;

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; start_s = 1'b0; stall_s = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_state", {tuple_obs(), mac_valid, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {tuple_obs(), mac_valid, busy, done}, 64'd0);

        run_pass(-1, 0, 1'b0);
        run_pass(4, 3, 1'b0);

        // start held high for a whole pass, then the restart that follows from IDLE
        run_pass(-1, 0, 1'b1);
        @(negedge clock);
        check("restart_from_idle", {tuple_obs(), mac_valid, busy}, {tup[0], 2'b11});
        start = 1'b0;

        for (int k = 1; k <= 20; k++) @(negedge clock);
        check("tuple20_before_reset", {tuple_obs(), mac_valid}, {tup[20], 1'b1});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {tuple_obs(), mac_valid, busy, done}, 64'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("idle_after_mid_reset", {tuple_obs(), mac_valid, busy, done}, 64'd0);
        run_pass(-1, 0, 1'b0);

        for (int k = 0; k < 19; k++) begin
            check($sformatf("small k=%0d", k),
                  {r_s, c_s, i_s, j_s, ic_s, oc_s, valid_s, first_s, last_s, busy_s, done_s},
                  {16'd0, vec[k].ic, vec[k].oc, vec[k].valid, vec[k].first, vec[k].last, vec[k].busy, vec[k].done});
            start_s = vec[k].start;
            stall_s = vec[k].stall;
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
